// File: rtl/cook_timer_if.sv
// cook_timer_if: keypad/tick inputs and BCD time/status outputs of the cook timer
interface cook_timer_if;
    logic       tick;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       Nclear;
    logic       mag_on;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       time_over;
    logic       done_pulse;
    logic [1:0] state_o;

    modport master (
        output tick, key_valid, key_digit, Nclear, mag_on,
        input  min_tens, min_ones, sec_tens, sec_ones, time_over, done_pulse, state_o
    );

    modport slave (
        input  tick, key_valid, key_digit, Nclear, mag_on,
        output min_tens, min_ones, sec_tens, sec_ones, time_over, done_pulse, state_o
    );
endinterface

// File: rtl/cook_timer.sv
// cook_timer: MM:SS BCD countdown feeding time_over to the magnetron control; TIMER_PRESCALER_EN builds an internal 1 Hz prescaler
module cook_timer #(
    parameter int CLK_DIV = 50_000_000,
    parameter int PRESC_W = 26
) (
    input  logic         clk,
    input  logic         rst,
    cook_timer_if.slave  io_bus
);
    localparam logic [1:0] ST_ENTRY = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    if ((64'd1 << PRESC_W) <= 64'(CLK_DIV)) begin : g_bad_presc_w
        $error("PRESC_W too small for CLK_DIV");
    end

    logic [1:0] r_state;
    logic [3:0] r_mt, r_mo, r_st, r_so;
    logic       r_time_over;
    logic       r_done_pulse;
    logic       w_tick;
    logic       w_key_ok;
    logic       w_b0, w_b1, w_b2;
    logic [3:0] w_d_mt, w_d_mo, w_d_st, w_d_so;
    logic       w_dec_zero;

`ifdef TIMER_PRESCALER_EN
    logic [PRESC_W-1:0] r_presc;

    assign w_tick = r_presc == PRESC_W'(CLK_DIV - 1);

    // Prescaler counts only while running so the first decrement lands a full period after start
    always_ff @(posedge clk) begin
        if (rst || !io_bus.Nclear || r_state != ST_RUN || !io_bus.mag_on || w_tick)
            r_presc <= '0;
        else
            r_presc <= r_presc + 1'b1;
    end
`else
    assign w_tick = io_bus.tick;
`endif

    assign w_key_ok   = io_bus.key_valid && io_bus.key_digit <= 4'd9;
    assign w_b0       = r_so == 4'd0;
    assign w_b1       = w_b0 && r_st == 4'd0;
    assign w_b2       = w_b1 && r_mo == 4'd0;
    assign w_d_so     = w_b0 ? 4'd9 : r_so - 4'd1;
    assign w_d_st     = w_b0 ? (r_st == 4'd0 ? 4'd5 : r_st - 4'd1) : r_st;
    assign w_d_mo     = w_b1 ? (r_mo == 4'd0 ? 4'd9 : r_mo - 4'd1) : r_mo;
    assign w_d_mt     = w_b2 ? (r_mt == 4'd0 ? 4'd9 : r_mt - 4'd1) : r_mt;
    assign w_dec_zero = {w_d_mt, w_d_mo, w_d_st, w_d_so} == 16'd0;

    // Entry/run/done sequencing; digits and time_over always update together
    always_ff @(posedge clk) begin
        if (rst || !io_bus.Nclear) begin
            {r_mt, r_mo, r_st, r_so} <= 16'd0;
            r_time_over  <= 1'b1;
            r_done_pulse <= 1'b0;
            r_state      <= ST_ENTRY;
        end else begin
            r_done_pulse <= 1'b0;
            case (r_state)
                ST_ENTRY: begin
                    if (w_key_ok) begin
                        {r_mt, r_mo, r_st, r_so} <= {r_mo, r_st, r_so, io_bus.key_digit};
                        r_time_over <= {r_mo, r_st, r_so, io_bus.key_digit} == 16'd0;
                    end
                    if (io_bus.mag_on && !r_time_over)
                        r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!io_bus.mag_on) begin
                        r_state <= ST_ENTRY;
                    end else if (w_tick) begin
                        {r_mt, r_mo, r_st, r_so} <= {w_d_mt, w_d_mo, w_d_st, w_d_so};
                        r_time_over <= w_dec_zero;
                        if (w_dec_zero) begin
                            r_done_pulse <= 1'b1;
                            r_state      <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_key_ok) begin
                        {r_mt, r_mo, r_st, r_so} <= {12'd0, io_bus.key_digit};
                        r_time_over <= io_bus.key_digit == 4'd0;
                        r_state     <= ST_ENTRY;
                    end
                end
                default: r_state <= ST_ENTRY;
            endcase
        end
    end

    assign io_bus.min_tens   = r_mt;
    assign io_bus.min_ones   = r_mo;
    assign io_bus.sec_tens   = r_st;
    assign io_bus.sec_ones   = r_so;
    assign io_bus.time_over  = r_time_over;
    assign io_bus.done_pulse = r_done_pulse;
    assign io_bus.state_o    = r_state;
endmodule

// File: tb/tb_cook_timer.sv
// tb_cook_timer: directed vector table plus multi-cycle sequences for cook_timer
module tb_cook_timer;
    typedef struct {
        logic        r, n, m, t, v;
        logic [3:0]  d;
        logic [15:0] dig;
        logic        to, dp;
        logic [1:0]  st;
        string       name;
    } vec_t;

    localparam logic [1:0] E = 2'd0;
    localparam logic [1:0] R = 2'd1;
    localparam logic [1:0] D = 2'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl[$];

    cook_timer_if bus();

    cook_timer #(.CLK_DIV(4), .PRESC_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [22:0] outs();
        return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones, bus.time_over, bus.done_pulse, bus.state_o};
    endfunction

    function automatic void add(input logic r, n, m, t, v, input logic [3:0] d,
                                input logic [15:0] dig, input logic to, dp, input logic [1:0] st, input string name);
        vec_t x;
        x.r = r; x.n = n; x.m = m; x.t = t; x.v = v; x.d = d;
        x.dig = dig; x.to = to; x.dp = dp; x.st = st; x.name = name;
        tbl.push_back(x);
    endfunction

    task automatic step(input logic r, n, m, t, v, input logic [3:0] d);
        @(negedge clk);
        rst = r; bus.Nclear = n; bus.mag_on = m; bus.tick = t; bus.key_valid = v; bus.key_digit = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [22:0] got, input logic [22:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    initial begin
        int c1, c2, dps;
        bus.tick = 0; bus.key_valid = 0; bus.key_digit = 0; bus.Nclear = 1; bus.mag_on = 0;
`ifndef TIMER_PRESCALER_EN
        //   r  n  m  t  v  d      digits    to dp st
        add(1, 1, 0, 0, 0, 4'd0, 16'h0000, 1, 0, E, "reset");
        add(0, 1, 0, 0, 1, 4'd1, 16'h0001, 0, 0, E, "key1");
        add(0, 1, 0, 0, 1, 4'd3, 16'h0013, 0, 0, E, "key3");
        add(0, 1, 0, 0, 1, 4'd0, 16'h0130, 0, 0, E, "key0 0130");
        add(0, 0, 0, 0, 0, 4'd0, 16'h0000, 1, 0, E, "clear1");
        add(0, 1, 0, 0, 1, 4'd3, 16'h0003, 0, 0, E, "key 0003");
        add(0, 1, 1, 0, 0, 4'd0, 16'h0003, 0, 0, R, "start 0003");
        add(0, 1, 1, 1, 0, 4'd0, 16'h0002, 0, 0, R, "tick 0002");
        add(0, 1, 1, 1, 0, 4'd0, 16'h0001, 0, 0, R, "tick 0001");
        add(0, 1, 1, 1, 0, 4'd0, 16'h0000, 1, 1, D, "tick done");
        add(0, 1, 1, 0, 0, 4'd0, 16'h0000, 1, 0, D, "done hold");
        add(0, 1, 0, 0, 1, 4'd1, 16'h0001, 0, 0, E, "done key");
        add(0, 1, 0, 0, 1, 4'd0, 16'h0010, 0, 0, E, "key 0010");
        add(0, 1, 0, 0, 1, 4'd0, 16'h0100, 0, 0, E, "key 0100");
        add(0, 1, 1, 0, 0, 4'd0, 16'h0100, 0, 0, R, "start 0100");
        add(0, 1, 1, 1, 0, 4'd0, 16'h0059, 0, 0, R, "tick 0059");
        add(0, 1, 0, 0, 0, 4'd0, 16'h0059, 0, 0, E, "pause 0059");
        add(0, 0, 0, 0, 0, 4'd0, 16'h0000, 1, 0, E, "clear2");
        add(0, 1, 0, 0, 1, 4'd1, 16'h0001, 0, 0, E, "key 0001");
        add(0, 1, 0, 0, 1, 4'd0, 16'h0010, 0, 0, E, "key 0010b");
        add(0, 1, 0, 0, 1, 4'd0, 16'h0100, 0, 0, E, "key 0100b");
        add(0, 1, 0, 0, 1, 4'd0, 16'h1000, 0, 0, E, "key 1000");
        add(0, 1, 1, 0, 0, 4'd0, 16'h1000, 0, 0, R, "start 1000");
        add(0, 1, 1, 1, 0, 4'd0, 16'h0959, 0, 0, R, "tick 0959");
        add(0, 0, 0, 0, 0, 4'd0, 16'h0000, 1, 0, E, "clear3");
        add(0, 1, 0, 0, 1, 4'd1, 16'h0001, 0, 0, E, "key 0001c");
        add(0, 1, 0, 0, 1, 4'd0, 16'h0010, 0, 0, E, "key 0010c");
        add(0, 1, 1, 0, 0, 4'd0, 16'h0010, 0, 0, R, "start 0010");
        add(0, 1, 0, 1, 0, 4'd0, 16'h0010, 0, 0, E, "pause with tick");
        add(0, 1, 1, 0, 0, 4'd0, 16'h0010, 0, 0, R, "resume");
        add(0, 1, 1, 1, 0, 4'd0, 16'h0009, 0, 0, R, "tick 0009");
        add(0, 1, 1, 1, 0, 4'd0, 16'h0008, 0, 0, R, "tick 0008");
        add(0, 1, 0, 0, 0, 4'd0, 16'h0008, 0, 0, E, "pause 0008");
        add(0, 0, 0, 0, 0, 4'd0, 16'h0000, 1, 0, E, "clear4");
        add(0, 1, 0, 0, 1, 4'd5, 16'h0005, 0, 0, E, "key 0005");
        add(0, 1, 0, 0, 1, 4'd0, 16'h0050, 0, 0, E, "key 0050");
        add(0, 1, 0, 0, 1, 4'd0, 16'h0500, 0, 0, E, "key 0500");
        add(0, 1, 1, 0, 0, 4'd0, 16'h0500, 0, 0, R, "start 0500");
        add(0, 0, 1, 1, 1, 4'd3, 16'h0000, 1, 0, E, "clear in run");
        add(0, 1, 1, 0, 0, 4'd0, 16'h0000, 1, 0, E, "no start at zero");
        add(0, 1, 0, 0, 1, 4'd1, 16'h0001, 0, 0, E, "shift 1");
        add(0, 1, 0, 0, 1, 4'd2, 16'h0012, 0, 0, E, "shift 2");
        add(0, 1, 0, 0, 1, 4'd3, 16'h0123, 0, 0, E, "shift 3");
        add(0, 1, 0, 0, 1, 4'd4, 16'h1234, 0, 0, E, "shift 4");
        add(0, 1, 0, 0, 1, 4'd5, 16'h2345, 0, 0, E, "shift overflow");
        add(0, 1, 0, 0, 1, 4'd12, 16'h2345, 0, 0, E, "reject 12");
        add(0, 1, 0, 0, 1, 4'd15, 16'h2345, 0, 0, E, "reject 15");
        add(0, 1, 1, 0, 0, 4'd0, 16'h2345, 0, 0, R, "start 2345");
        add(0, 1, 1, 0, 1, 4'd7, 16'h2345, 0, 0, R, "key in run");
        add(0, 1, 1, 1, 1, 4'd7, 16'h2344, 0, 0, R, "tick beats key");
        add(0, 0, 0, 0, 0, 4'd0, 16'h0000, 1, 0, E, "clear5");
        add(0, 1, 0, 0, 1, 4'd9, 16'h0009, 0, 0, E, "key 0009");
        add(0, 1, 0, 0, 1, 4'd9, 16'h0099, 0, 0, E, "key 0099");
        add(0, 1, 1, 0, 0, 4'd0, 16'h0099, 0, 0, R, "start 0099");
        add(0, 1, 1, 1, 0, 4'd0, 16'h0098, 0, 0, R, "tick 0098");
        add(1, 1, 1, 1, 0, 4'd0, 16'h0000, 1, 0, E, "reset in run");

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].n, tbl[i].m, tbl[i].t, tbl[i].v, tbl[i].d);
            check(tbl[i].name, outs(), {tbl[i].dig, tbl[i].to, tbl[i].dp, tbl[i].st});
        end

        step(1, 1, 0, 0, 0, 4'd0);
        step(0, 1, 0, 0, 1, 4'd2);
        step(0, 1, 1, 0, 0, 4'd0);
        step(0, 1, 1, 1, 0, 4'd0);
        step(0, 1, 1, 1, 0, 4'd0);
        check("seq done edge", outs(), {16'h0000, 1'b1, 1'b1, D});
        dps = 0;
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 1, 1, 0, 4'd0);
            dps += int'(bus.done_pulse);
        end
        check("seq pulse width", 23'(dps), 23'd0);
        check("seq done stays", outs(), {16'h0000, 1'b1, 1'b0, D});
`else
        step(1, 1, 0, 0, 0, 4'd0);
        check("presc reset", outs(), {16'h0000, 1'b1, 1'b0, E});
        step(0, 1, 0, 0, 1, 4'd2);
        step(0, 1, 1, 0, 0, 4'd0);
        check("presc start", outs(), {16'h0002, 1'b0, 1'b0, R});
        c1 = 0; c2 = 0;
        for (int k = 1; k <= 20; k++) begin
            step(0, 1, 1, 1, 0, 4'd0);
            if (c1 == 0 && {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones} == 16'h0001) c1 = k;
            if (c2 == 0 && bus.done_pulse) c2 = k;
        end
        check("presc first tick", 23'(c1), 23'd4);
        check("presc done", 23'(c2), 23'd8);
        check("presc end", outs(), {16'h0000, 1'b1, 1'b0, D});
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/cook_timer.md
Name: cook_timer

Overview:
- Countdown timer that sits directly upstream of the magnetron on/off control and produces its `time_over` input.
- Keypad digits are shifted into a 4-digit BCD MM:SS register.
- The register counts down one second per tick while the magnetron is on.
- `time_over` asserts whenever the remaining time is 00:00.
- The digit outputs also feed the display driver.

Parameters:
- CLK_DIV, 50_000_000, clock cycles per second. Used only when the internal prescaler is compiled in.
- PRESC_W, 26, width of the prescaler counter. Must satisfy 2^PRESC_W > CLK_DIV.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle 1 Hz enable pulse. Ignored when TIMER_PRESCALER_EN is defined.
- key_valid  in  1  one-cycle strobe; `key_digit` is valid.
- key_digit  in  4  BCD digit 0-9. Values 10-15 are ignored.
- Nclear  in  1  active-low clear; synchronous, level-sensitive.
- mag_on  in  1  magnetron state from the on/off latch; 1 = counting allowed.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  remaining time, BCD, registered.
- time_over  out  1  registered; 1 when all four digits are 0.
- done_pulse  out  1  registered; one-cycle pulse when a countdown reaches 00:00.
- state_o  out  2  current FSM state, for debug and display.

Behaviour:
- Reset, rst=1 on a clock edge:
  - all digits 0
  - time_over=1
  - done_pulse=0
  - state=ENTRY (2'd0)
  - prescaler counter 0
- Priority within a cycle: rst > Nclear=0 > count/tick > key entry.
- FSM states: ENTRY=0, RUN=1, DONE=2. Code 3 is illegal and recovers to ENTRY.
- ENTRY:
  - key_valid with a digit of 9 or less shifts left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit.
  - The old min_tens is discarded.
  - Go to RUN when mag_on=1 and time_over=0.
  - If mag_on=1 while the time is 00:00, stay in ENTRY; the downstream control is responsible for refusing start.
- RUN:
  - Keys are ignored.
  - Each tick decrements by one second.
    - sec_ones: 1-9 decrements; 0 wraps to 9 and borrows from sec_tens.
    - sec_tens: nonzero decrements; 0 wraps to 5 and borrows from minutes.
    - Minutes decrement as 2-digit BCD (00-99).
    - Entered seconds above 59 (e.g. 00:99) count down normally: 99, 98 … 90, 89 … 00.
  - The tick that produces 00:00 also sets time_over=1 and done_pulse=1 in the same register update, then state becomes DONE.
  - mag_on=0 (door opened or stop pressed) pauses: return to ENTRY with digits held.
    - Keys then shift into the held value (standard microwave "add digits" behaviour is not implemented; the shift rule applies unchanged).
  - A tick in the same cycle that mag_on falls is ignored.
- DONE:
  - Digits are 0 and time_over=1.
  - The first key_valid shifts into the zero register and goes to ENTRY.
  - mag_on has no effect.
- Nclear=0 in any state: digits 0, time_over=1, done_pulse=0, state ENTRY. A simultaneous tick or key is dropped.
- time_over is recomputed in every cycle that the digits change. It is never stale by more than the update cycle.
- done_pulse is high for exactly one cycle and only on a RUN-to-DONE transition.
- There is no latency from tick to digit change: digits update on the same edge at which tick is sampled high.

Optional Feature:
- Macro: TIMER_PRESCALER_EN.
- Defined:
  - An internal counter runs 0..CLK_DIV-1 and generates the tick internally on wrap; the tick port is unused.
  - The counter runs only in RUN and is cleared to 0 on entering RUN, so the first decrement occurs a full CLK_DIV cycles after start.
  - rst and Nclear also clear the counter.
- Not defined: the external tick port is used directly and there is no prescaler logic.

Test Plan:
- Reset then keys 1,3,0: digits 01:30, time_over=0, state ENTRY.
- Entry 00:03, mag_on=1, three ticks:
  - digits go 02, 01, 00.
  - On the third tick: time_over=1, done_pulse=1 for exactly 1 cycle, state DONE.
- Entry 01:00, mag_on=1, one tick: digits 00:59. Then 10:00 with one tick gives 09:59.
- Pause and resume:
  - In RUN at 00:10, drop mag_on with a tick in the same cycle: digits stay 00:10, state ENTRY.
  - Raise mag_on again and give two ticks: 00:08.
- Nclear=0 during RUN at 05:00 together with a tick: digits 00:00, time_over=1, done_pulse=0, state ENTRY.
- Key shift overflow and rejection:
  - Keys 1,2,3,4,5 give 23:45.
  - key_digit=12 with key_valid leaves the digits unchanged.
  - Keys while in RUN are ignored.
- With TIMER_PRESCALER_EN and CLK_DIV=4:
  - Entry 00:02, start: 00:01 four cycles after RUN entry.
  - 00:00 with done_pulse eight cycles after RUN entry.
